fifo_byte_serializer: RTL and testbench
=======================================

# fifo_byte_serializer

Drain stage that sits directly downstream of the team's word FIFO. It pops `len_data`-bit words from the FIFO's first-word-fall-through read port and emits each as `len_data/len_out` narrower beats, LSB slice first, on a valid/ready stream. It lets a 32-bit producer feed a byte-wide consumer, such as a UART TX or link PHY, without bubbles while the consumer keeps ready high.

## Interface
- `len_data`, default 32: FIFO word width; must be an integer multiple of `len_out`.
- `len_out`, default 8: output beat width.
- `n_beats`, localparam = `len_data/len_out`: beats per word.
- `idx_w`, localparam = max(1, `$clog2(n_beats)`): beat index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_fifo_data`  in  `len_data`  FIFO head word; valid whenever `i_fifo_empty`=0.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `o_fifo_read`  out  1  pop strobe; the FIFO advances at the same edge.
- `o_data`  out  `len_out`  current beat.
- `o_valid`  out  1  beat valid.
- `i_ready`  in  1  downstream accepts the beat when `o_valid`&&`i_ready` at an edge.
- `o_busy`  out  1  high while a word is being sent (state SEND).
- `dbg_beats`  out  16  accepted-beat counter; present only with `SER_DBG_COUNT_EN`.

## Operation
- Two-state FSM: IDLE and SEND. Internal state: `shreg` (`len_data`), `idx` (`idx_w`).
- Load condition: (state==IDLE && !`i_fifo_empty`) or (state==SEND && last-beat handshake && !`i_fifo_empty`).
- `o_fifo_read` is combinational and equals the load condition gated by !`rst`. It is never asserted while `i_fifo_empty`=1.
- On load: `shreg` <= `i_fifo_data`, `idx` <= 0, state <= SEND.
- In IDLE: `o_valid`=0 and `o_data`=0.
- In SEND: `o_valid`=1 and `o_data` = `shreg[idx*len_out +: len_out]`.
  - While `i_ready`=0, `o_data` and `o_valid` hold stable.
  - Handshake with `idx` < `n_beats`-1: `idx` <= `idx`+1.
  - Handshake with `idx` == `n_beats`-1: reload if the FIFO is non-empty, otherwise go to IDLE and set `idx` <= 0.
- A word is owned by this block once popped. It is never re-read or pushed back.
- `n_beats`==1 is legal: every handshake is a last-beat handshake.

## Timing
- Reset values: state IDLE; `idx`=0; `shreg`=0; `o_valid`=0; `o_busy`=0; `o_data`=0; `o_fifo_read`=0 while `rst`=1; `dbg_beats`=0.
- Latency: FIFO non-empty in IDLE at cycle t gives a pop at edge t and the first beat valid in cycle t+1.
- Throughput: with `i_ready` held high, one beat per cycle and zero bubbles between consecutive words. Pops occur every `n_beats` cycles.
- The FIFO going empty during SEND has no effect until the last-beat handshake.
- Reset mid-word: remaining beats of the current word are discarded. `o_valid`=0 in the cycle after the reset edge. The next word starts at beat 0.
- A write into an empty FIFO at edge t shows up as a pop at edge t+1, given the FIFO's registered empty flag.

## Configuration
- `SER_DBG_COUNT_EN` defined:
  - `dbg_beats` port exists.
  - It increments by 1 on every `o_valid`&&`i_ready` edge.
  - It wraps from 0xFFFF to 0 and clears on `rst`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Single word: FIFO holds 0xA1B2C3D4, `i_ready`=1, empty goes low in cycle t.
  - One `o_fifo_read` pulse at t.
  - `o_data` = D4, C3, B2, A1 in cycles t+1..t+4.
  - `o_valid`=0 at t+5; `o_busy` follows `o_valid`.
- Backpressure: same word, `i_ready`=0 for 3 cycles while `o_data`=C3.
  - C3 and `o_valid`=1 hold for those 3 cycles.
  - B2 follows in the cycle after `i_ready` returns high; no beat is lost or duplicated.
- Back-to-back: FIFO holds 0x11223344 and 0x55667788, `i_ready`=1.
  - 8 consecutive beats 44,33,22,11,88,77,66,55 with no gap.
  - Pops at t and t+4.
- Empty FIFO: `i_fifo_empty`=1 for 20 cycles with `i_ready` toggling.
  - `o_fifo_read`=0, `o_valid`=0 and `o_data`=0 throughout.
- Reset mid-word: assert `rst` for 1 cycle after beats D4 and C3 are accepted, with 0xCAFEF00D next in the FIFO.
  - `o_valid`=0 after the reset edge.
  - Then 0D, F0, FE, CA; B2 and A1 are never emitted.
- With `SER_DBG_COUNT_EN`:
  - After the back-to-back test, `dbg_beats`=8.
  - Preloaded near wrap by forcing 16384 words, the counter reads 0 after the 65536th beat.

Source files
------------

// File: rtl/fifo_byte_serializer_if.sv
// fifo_byte_serializer_if
// Bundles the FIFO read-port signals and the narrow valid/ready output stream
// of fifo_byte_serializer. Signal names are given from the serializer's point
// of view: i_* flow into the serializer, o_* flow out of it.
//   master : the serializer itself
//   slave  : the surroundings (FIFO read port plus downstream consumer)
interface fifo_byte_serializer_if #(
    parameter int len_data = 32,
    parameter int len_out  = 8
);
    logic [len_data-1:0] i_fifo_data;
    logic                i_fifo_empty;
    logic                o_fifo_read;
    logic [len_out-1:0]  o_data;
    logic                o_valid;
    logic                i_ready;
    logic                o_busy;

    modport master (
        input  i_fifo_data,
        input  i_fifo_empty,
        input  i_ready,
        output o_fifo_read,
        output o_data,
        output o_valid,
        output o_busy
    );

    modport slave (
        output i_fifo_data,
        output i_fifo_empty,
        output i_ready,
        input  o_fifo_read,
        input  o_data,
        input  o_valid,
        input  o_busy
    );
endinterface

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer
// Pops len_data-bit words from a first-word-fall-through FIFO and emits each as
// len_data/len_out beats, LSB slice first, on a valid/ready stream. With the
// consumer holding ready high, consecutive words stream without bubbles: the
// next word is popped on the same edge that accepts the last beat.
//
// Optional feature macro: SER_DBG_COUNT_EN
//   defined   -> 16-bit dbg_beats port counting accepted beats (wraps, cleared by rst)
//   undefined -> port and counter absent
module fifo_byte_serializer #(
    parameter int len_data = 32,
    parameter int len_out  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_byte_serializer_if.master  bus
`ifdef SER_DBG_COUNT_EN
    ,
    output logic [15:0]             dbg_beats
`endif
);
    localparam int n_beats = len_data / len_out;
    localparam int idx_w   = (n_beats > 1) ? $clog2(n_beats) : 1;
    localparam logic [idx_w-1:0] IDX_LAST = idx_w'(n_beats - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t               r_state;
    logic [len_data-1:0]  r_shreg;
    logic [idx_w-1:0]     r_idx;
    logic [len_out-1:0]   r_data;
    logic                 r_valid;
    logic                 r_busy;

    logic [len_out-1:0]   w_beats [n_beats];
    logic [len_out-1:0]   w_next_beat;
    logic [idx_w-1:0]     w_idx_inc;
    logic                 w_hs;
    logic                 w_last;
    logic                 w_load;

    // Slice the held word into beat-sized pieces so the next beat is a plain mux.
    generate
        for (genvar gi = 0; gi < n_beats; gi++) begin : g_beats
            assign w_beats[gi] = r_shreg[gi*len_out +: len_out];
        end
    endgenerate

    assign w_idx_inc = r_idx + idx_w'(1);

    // With a single beat per word there is never a "next beat" inside a word.
    generate
        if (n_beats > 1) begin : g_multi
            assign w_next_beat = w_beats[w_idx_inc];
        end else begin : g_single
            assign w_next_beat = '0;
        end
    endgenerate

    assign w_hs   = r_valid && bus.i_ready;
    assign w_last = (r_idx == IDX_LAST);
    // Pop when idle, or when the final beat leaves so the next word follows gap-free.
    assign w_load = !bus.i_fifo_empty &&
                    ((r_state == S_IDLE) || ((r_state == S_SEND) && w_hs && w_last));

    assign bus.o_fifo_read = w_load && !rst;
    assign bus.o_data      = r_data;
    assign bus.o_valid     = r_valid;
    assign bus.o_busy      = r_busy;

    // Serializer FSM: loads a word, steps the beat index on each handshake,
    // reloads or returns to idle after the last beat. Outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_SEND;
                        r_shreg <= bus.i_fifo_data;
                        r_idx   <= '0;
                        r_data  <= bus.i_fifo_data[len_out-1:0];
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (w_last) begin
                            if (w_load) begin
                                r_shreg <= bus.i_fifo_data;
                                r_idx   <= '0;
                                r_data  <= bus.i_fifo_data[len_out-1:0];
                            end else begin
                                r_state <= S_IDLE;
                                r_idx   <= '0;
                                r_data  <= '0;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_idx  <= w_idx_inc;
                            r_data <= w_next_beat;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SER_DBG_COUNT_EN
    logic [15:0] r_dbg_beats;

    // Count every accepted beat; natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_beats <= '0;
        end else if (w_hs) begin
            r_dbg_beats <= r_dbg_beats + 16'd1;
        end
    end

    assign dbg_beats = r_dbg_beats;
`endif

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb_fifo_byte_serializer
// Directed bench for fifo_byte_serializer: a small FWFT FIFO model feeds the
// block, inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_fifo_byte_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fifo_byte_serializer_if #(.len_data(32), .len_out(8)) bus ();

`ifdef SER_DBG_COUNT_EN
    logic [15:0] dbg_beats;
`endif

    fifo_byte_serializer #(.len_data(32), .len_out(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef SER_DBG_COUNT_EN
        ,
        .dbg_beats (dbg_beats)
`endif
    );

    // FIFO model: 64 entries, FWFT read port.
    logic [31:0] mem [64];
    logic [5:0]  rd_ptr = '0;
    logic [5:0]  wr_ptr = '0;
    logic        inf_mode = 1'b0;

    assign bus.i_fifo_empty = inf_mode ? 1'b0 : (rd_ptr == wr_ptr);
    assign bus.i_fifo_data  = mem[rd_ptr];

    always @(posedge clk) begin
        if (bus.o_fifo_read) rd_ptr <= rd_ptr + 6'd1;
    end

    logic [7:0] exp_a [4];
    logic [7:0] exp_b [8];
    logic [7:0] exp_c [4];

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        push(32'h1234_5678);
        #1;
        n_vec++; if (bus.o_fifo_read !== 1'b0) begin n_bad++; $display("FAIL reset_read got=%b exp=0", bus.o_fifo_read); end
        n_vec++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        n_vec++; if (bus.o_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", bus.o_data); end
        n_vec++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid got=%b exp=0", bus.o_valid); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        @(negedge clk);
        push(32'hA1B2_C3D4);
        bus.i_ready = 1'b1;
        #1;
        n_vec++; if (bus.o_fifo_read !== 1'b1) begin n_bad++; $display("FAIL single_pop got=%b exp=1", bus.o_fifo_read); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_vec++; if (bus.o_data !== exp_a[i]) begin n_bad++; $display("FAIL single_data[%0d] got=%h exp=%h", i, bus.o_data, exp_a[i]); end
            n_vec++; if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL single_valid[%0d] got=%b/%b exp=1/1", i, bus.o_valid, bus.o_busy); end
            n_vec++; if (bus.o_fifo_read !== 1'b0) begin n_bad++; $display("FAIL single_nopop[%0d] got=%b exp=0", i, bus.o_fifo_read); end
        end
        @(negedge clk); #1;
        n_vec++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL single_end got=%b/%b exp=0/0", bus.o_valid, bus.o_busy); end
        n_vec++; if (bus.o_data !== 8'h00) begin n_bad++; $display("FAIL single_end_data got=%h exp=00", bus.o_data); end
        $display("test_single word A1B2C3D4 sent");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        push(32'hA1B2_C3D4);
        bus.i_ready = 1'b1;
        #1;
        n_vec++; if (bus.o_fifo_read !== 1'b1) begin n_bad++; $display("FAIL bp_pop got=%b exp=1", bus.o_fifo_read); end
        @(negedge clk); #1;
        n_vec++; if (bus.o_data !== 8'hD4) begin n_bad++; $display("FAIL bp_first got=%h exp=d4", bus.o_data); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_ready = 1'b0;
            #1;
            n_vec++; if (bus.o_data !== 8'hC3 || bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold[%0d] got=%h/%b exp=c3/1", i, bus.o_data, bus.o_valid); end
        end
        @(negedge clk);
        bus.i_ready = 1'b1;
        #1;
        n_vec++; if (bus.o_data !== 8'hC3 || bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL bp_release got=%h/%b exp=c3/1", bus.o_data, bus.o_valid); end
        @(negedge clk); #1;
        n_vec++; if (bus.o_data !== 8'hB2) begin n_bad++; $display("FAIL bp_b2 got=%h exp=b2", bus.o_data); end
        @(negedge clk); #1;
        n_vec++; if (bus.o_data !== 8'hA1) begin n_bad++; $display("FAIL bp_a1 got=%h exp=a1", bus.o_data); end
        @(negedge clk); #1;
        n_vec++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL bp_end got=%b exp=0", bus.o_valid); end
        $display("test_backpressure word A1B2C3D4 sent with 3-cycle stall");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(32'h1122_3344);
        push(32'h5566_7788);
        bus.i_ready = 1'b1;
        #1;
        n_vec++; if (bus.o_fifo_read !== 1'b1) begin n_bad++; $display("FAIL b2b_pop0 got=%b exp=1", bus.o_fifo_read); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            n_vec++; if (bus.o_data !== exp_b[i] || bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_data[%0d] got=%h/%b exp=%h/1", i, bus.o_data, bus.o_valid, exp_b[i]); end
            n_vec++; if (bus.o_fifo_read !== (i == 3)) begin n_bad++; $display("FAIL b2b_pop[%0d] got=%b exp=%b", i, bus.o_fifo_read, (i == 3)); end
        end
        @(negedge clk); #1;
        n_vec++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end got=%b exp=0", bus.o_valid); end
`ifdef SER_DBG_COUNT_EN
        n_vec++; if (dbg_beats !== 16'd8) begin n_bad++; $display("FAIL dbg_after_b2b got=%0d exp=8", dbg_beats); end
`endif
        $display("test_back_to_back words 11223344 55667788 sent");
    endtask

    task automatic test_empty();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.i_ready = i[0];
            #1;
            n_vec++; if (bus.o_fifo_read !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_data !== 8'h00) begin
                n_bad++; $display("FAIL empty[%0d] got read=%b valid=%b data=%h exp 0/0/00", i, bus.o_fifo_read, bus.o_valid, bus.o_data);
            end
        end
        $display("test_empty 20 idle cycles");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        push(32'hA1B2_C3D4);
        push(32'hCAFE_F00D);
        bus.i_ready = 1'b1;
        #1;
        n_vec++; if (bus.o_fifo_read !== 1'b1) begin n_bad++; $display("FAIL rm_pop got=%b exp=1", bus.o_fifo_read); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_vec++; if (bus.o_data !== exp_a[i]) begin n_bad++; $display("FAIL rm_pre[%0d] got=%h exp=%h", i, bus.o_data, exp_a[i]); end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (bus.o_fifo_read !== 1'b0) begin n_bad++; $display("FAIL rm_rst_read got=%b exp=0", bus.o_fifo_read); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (bus.o_valid !== 1'b0 || bus.o_data !== 8'h00) begin n_bad++; $display("FAIL rm_after_rst got=%b/%h exp=0/00", bus.o_valid, bus.o_data); end
        n_vec++; if (bus.o_fifo_read !== 1'b1) begin n_bad++; $display("FAIL rm_repop got=%b exp=1", bus.o_fifo_read); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_vec++; if (bus.o_data !== exp_c[i] || bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL rm_data[%0d] got=%h/%b exp=%h/1", i, bus.o_data, bus.o_valid, exp_c[i]); end
        end
        @(negedge clk); #1;
        n_vec++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL rm_end got=%b exp=0", bus.o_valid); end
        $display("test_reset_mid word CAFEF00D sent after reset");
    endtask

`ifdef SER_DBG_COUNT_EN
    task automatic test_dbg_wrap();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inf_mode = 1'b1;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 65536; i++) @(negedge clk);
        #1;
        n_vec++; if (dbg_beats !== 16'hFFFF) begin n_bad++; $display("FAIL dbg_pre_wrap got=%h exp=ffff", dbg_beats); end
        @(negedge clk); #1;
        n_vec++; if (dbg_beats !== 16'h0000) begin n_bad++; $display("FAIL dbg_wrap got=%h exp=0000", dbg_beats); end
        inf_mode = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        wr_ptr = rd_ptr;
        rst = 1'b0;
        #1;
        n_vec++; if (dbg_beats !== 16'h0000) begin n_bad++; $display("FAIL dbg_rst got=%h exp=0000", dbg_beats); end
        $display("test_dbg_wrap 65536 beats counted");
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        exp_a = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        exp_c = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        bus.i_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_empty();
        test_reset_mid();
`ifdef SER_DBG_COUNT_EN
        test_dbg_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
